pipeline_trace_unit: RTL and testbench

Hardware retirement tracer for the MIPS pipeline CPU: it watches the writeback-stage retire bus, classifies each retired instruction, and stamps it with a cycle count. It buffers the resulting trace records in a FIFO and drains them to a host reader over a valid/ready port. It also raises a sticky halt request after a programmed cycle budget. It sits beside `mips_pipeline`, fed by its retire signals; the host/debug side consumes the records.

---
 rtl/trace_pkg.sv | 84 ++++++++
 rtl/pipeline_trace_unit_if.sv | 28 ++
 rtl/trace_fifo.sv | 79 +++++++
 rtl/pipeline_trace_unit.sv | 109 ++++++++++
 tb/tb_pipeline_trace_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared constants and the instruction classifier for the retirement tracer.
package trace_pkg;

  typedef enum logic [3:0] {
    CLS_UNKNOWN = 4'd0,
    CLS_ADD     = 4'd1,
    CLS_SUB     = 4'd2,
    CLS_AND     = 4'd3,
    CLS_OR      = 4'd4,
    CLS_NOP     = 4'd5,
    CLS_SLL     = 4'd6,
    CLS_MULTU   = 4'd7,
    CLS_MFHI    = 4'd8,
    CLS_MFLO    = 4'd9,
    CLS_JR      = 4'd10,
    CLS_LW      = 4'd11,
    CLS_SW      = 4'd12,
    CLS_BEQ     = 4'd13,
    CLS_J       = 4'd14,
    CLS_ANDI    = 4'd15
  } trc_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;

  localparam int CYC_W = 16;
  localparam int CLS_W = 4;
  localparam int PC_W  = 32;
  localparam int WD_W  = 32;
  localparam int REC_W = 84;

  localparam int WD_LSB  = 0;
  localparam int PC_LSB  = 32;
  localparam int CLS_LSB = 64;
  localparam int CYC_LSB = 68;

  function automatic trc_cls_e trc_classify(input logic [31:0] instr);
    trc_cls_e cls;
    cls = CLS_UNKNOWN;
    // The all-zero word is sll $0,$0,0; it is reported as NOP, not SLL.
    if (instr == 32'h0) begin
      cls = CLS_NOP;
    end else begin
      case (instr[31:26])
        OP_RTYPE: begin
          case (instr[5:0])
            FN_ADD:   cls = CLS_ADD;
            FN_SUB:   cls = CLS_SUB;
            FN_AND:   cls = CLS_AND;
            FN_OR:    cls = CLS_OR;
            FN_SLL:   cls = CLS_SLL;
            FN_MULTU: cls = CLS_MULTU;
            FN_MFHI:  cls = CLS_MFHI;
            FN_MFLO:  cls = CLS_MFLO;
            FN_JR:    cls = CLS_JR;
            default:  cls = CLS_UNKNOWN;
          endcase
        end
        OP_LW:   cls = CLS_LW;
        OP_SW:   cls = CLS_SW;
        OP_BEQ:  cls = CLS_BEQ;
        OP_J:    cls = CLS_J;
        OP_ANDI: cls = CLS_ANDI;
        default: cls = CLS_UNKNOWN;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/pipeline_trace_unit_if.sv
// Retire bus plus trace read port of the tracer; slave is the tracer side.
interface pipeline_trace_unit_if;
  import trace_pkg::*;

  logic              retire_valid;
  logic [31:0]       retire_pc;
  logic [31:0]       retire_instr;
  logic [31:0]       retire_wd;

  logic              trc_valid;
  logic              trc_ready;
  logic [REC_W-1:0]  trc_data;

  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              halt;

  modport master (
    output retire_valid, retire_pc, retire_instr, retire_wd, trc_ready,
    input  trc_valid, trc_data, overflow, drop_cnt, halt
  );

  modport slave (
    input  retire_valid, retire_pc, retire_instr, retire_wd, trc_ready,
    output trc_valid, trc_data, overflow, drop_cnt, halt
  );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with count-based full/empty and a registered head that reads 0 when empty.
module trace_fifo #(
  parameter int WIDTH = 84,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = head_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned and no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Head is preloaded so the read port comes straight from a register.
    if (count_d == '0) begin
      head_d = '0;
    end else if (do_pop) begin
      head_d = (count_q == CNT_W'(1)) ? push_data : mem_q[rd_ptr_d];
    end else if (empty && do_push) begin
      head_d = push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible because count and head_q gate the output.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pipeline_trace_unit.sv
// Retirement tracer: classifies retired instructions, stamps them with a cycle count and queues them for a host.
// Define TRACE_WD_EN to store and emit the register write data in trc_data[31:0].
module pipeline_trace_unit
  import trace_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int STOP_CYCLE = 200
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_trace_unit_if.slave bus
);

  localparam logic [CYC_W-1:0] STOP_C  = CYC_W'(STOP_CYCLE);
  localparam bit               HALT_EN = (STOP_CYCLE != 0);

`ifdef TRACE_WD_EN
  localparam int STORE_LSB = WD_LSB;
`else
  localparam int STORE_LSB = PC_LSB;
`endif
  localparam int STORE_W = REC_W - STORE_LSB;

  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               halt_q, halt_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  trc_cls_e           cls;
  logic               capture, pop, drop;
  logic               fifo_empty, fifo_full;
  logic [REC_W-1:0]   rec;
  logic [STORE_W-1:0] store_in, store_out;

  assign cls     = trc_classify(bus.retire_instr);
  assign capture = bus.retire_valid && !halt_q;
  assign pop     = bus.trc_ready && !fifo_empty;
  assign drop    = capture && fifo_full && !pop;

  always_comb begin
    rec = '0;
    rec[CYC_LSB +: CYC_W] = cyc_q;
    rec[CLS_LSB +: CLS_W] = cls;
    rec[PC_LSB  +: PC_W]  = bus.retire_pc;
    rec[WD_LSB  +: WD_W]  = bus.retire_wd;
  end

  assign store_in = rec[REC_W-1:STORE_LSB];

  always_comb begin
    cyc_d      = cyc_q;
    halt_d     = halt_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    // The counter freezes once halted; halt rises on the edge cyc reaches the budget.
    if (!halt_q) begin
      cyc_d = cyc_q + CYC_W'(1);
      if (HALT_EN && (cyc_d == STOP_C)) halt_d = 1'b1;
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q      <= '0;
      halt_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      cyc_q      <= cyc_d;
      halt_q     <= halt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  trace_fifo #(
    .WIDTH (STORE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (store_in),
    .pop       (pop),
    .head      (store_out),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

`ifdef TRACE_WD_EN
  assign bus.trc_data = store_out;
`else
  logic [STORE_LSB-1:0] unused_wd_bits;
  assign unused_wd_bits = rec[STORE_LSB-1:0];
  assign bus.trc_data   = {store_out, {WD_W{1'b0}}};
`endif

  assign bus.trc_valid = !fifo_empty;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.halt      = halt_q;

endmodule

// File: tb/tb_pipeline_trace_unit.sv
// Scoreboard bench for pipeline_trace_unit: a queue-level reference model predicts records, a negedge monitor compares.
module tb_pipeline_trace_unit;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int STOP  = 200;
  localparam int FNS [10] = '{32, 34, 36, 37, 0, 25, 16, 18, 8, 42};
  localparam int OPS [7]  = '{35, 43, 4, 2, 12, 8, 13};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pipeline_trace_unit_if bus();

  pipeline_trace_unit #(
    .DEPTH      (DEPTH),
    .STOP_CYCLE (STOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference classification tables indexed by funct (R-type) and by opcode.
  int r_cls [64];
  int i_cls [64];
  initial begin
    for (int i = 0; i < 64; i++) begin
      r_cls[i] = 0;
      i_cls[i] = 0;
    end
    r_cls[32] = 1; r_cls[34] = 2; r_cls[36] = 3; r_cls[37] = 4; r_cls[0] = 6;
    r_cls[25] = 7; r_cls[16] = 8; r_cls[18] = 9; r_cls[8] = 10;
    i_cls[35] = 11; i_cls[43] = 12; i_cls[4] = 13; i_cls[2] = 14; i_cls[12] = 15;
  end

  function automatic int ref_cls(input logic [31:0] w);
    if (w == 32'h0) return 5;
    if (w[31:26] == 6'd0) return r_cls[int'(w[5:0])];
    return i_cls[int'(w[31:26])];
  endfunction

  function automatic logic [31:0] wd_seen(input logic [31:0] wd);
`ifdef TRACE_WD_EN
    return wd;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [REC_W-1:0] exp_rec(input int cyc, input logic [31:0] instr,
                                               input logic [31:0] pc, input logic [31:0] wd);
    logic [15:0] c;
    logic [3:0]  k;
    c = 16'(cyc);
    k = 4'(ref_cls(instr));
    return {c, k, pc, wd_seen(wd)};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4)       return {6'd0, r[25:7], 1'b1, 6'(FNS[$urandom_range(0, 9)])};
    else if (k < 7)  return {6'(OPS[$urandom_range(0, 6)]), r[25:0]};
    else if (k == 7) return 32'h0;
    else             return r;
  endfunction

  // Reference model state: expected records in order, occupancy, edges since reset, drops.
  logic [REC_W-1:0] exp_q [$];
  int               occ = 0;
  int               edges = 0;
  int               drop_m = 0;
  bit               ovf_m = 1'b0;
  int               pop_count = 0;
  logic [15:0]      last_pop_cyc = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      occ    = 0;
      edges  = 0;
      drop_m = 0;
      ovf_m  = 1'b0;
    end else begin
      bit halted, pop_m, cap;
      halted = (edges >= STOP);
      pop_m  = (occ > 0) && bus.trc_ready;
      cap    = bus.retire_valid && !halted;
      if (cap) begin
        if (occ < DEPTH || pop_m) begin
          exp_q.push_back(exp_rec(edges, bus.retire_instr, bus.retire_pc, bus.retire_wd));
          occ++;
        end else begin
          ovf_m = 1'b1;
          if (drop_m < 255) drop_m++;
        end
      end
      if (pop_m) occ--;
      if (!halted) edges++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("trc_valid", bus.trc_valid, occ > 0);
      check("halt", bus.halt, edges >= STOP);
      check("overflow", bus.overflow, ovf_m);
      check("drop_cnt", bus.drop_cnt, 8'(drop_m));
      if (bus.trc_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", 1'b1, 1'b0);
        end else begin
          check("trc_data", bus.trc_data, exp_q[0]);
          if (bus.trc_ready) begin
            last_pop_cyc = bus.trc_data[83:68];
            void'(exp_q.pop_front());
            pop_count++;
          end
        end
      end else begin
        check("trc_data_empty", bus.trc_data, '0);
      end
    end
  end

  task automatic cycle(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] wd, input bit rdy);
    bus.retire_valid = v;
    bus.retire_instr = instr;
    bus.retire_pc    = pc;
    bus.retire_wd    = wd;
    bus.trc_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.retire_valid = 1'b0;
    bus.trc_ready    = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid", bus.trc_valid, 1'b0);
    check("rst_data", bus.trc_data, '0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_drop", bus.drop_cnt, 8'd0);
    check("rst_halt", bus.halt, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end in time");
    $fatal(1);
  end

  initial begin
    bus.retire_valid = 1'b0;
    bus.retire_instr = '0;
    bus.retire_pc    = '0;
    bus.retire_wd    = '0;
    bus.trc_ready    = 1'b0;

    // Directed classification: add at cyc 5, then nop and lw.
    do_reset();
    repeat (5) cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0022_1820, 32'h4, 32'h7, 1'b0);
    cycle(1'b1, 32'h0000_0000, 32'h8, 32'h9, 1'b0);
    cycle(1'b1, 32'h8C01_0000, 32'hC, 32'hDEAD_BEEF, 1'b0);
    check("add_record", bus.trc_data, {16'd5, 4'd1, 32'h4, wd_seen(32'h7)});
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("nop_cls", bus.trc_data[67:64], 4'd5);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("lw_cls", bus.trc_data[67:64], 4'd11);
    check("lw_wd", bus.trc_data[31:0], wd_seen(32'hDEAD_BEEF));
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("drained_valid", bus.trc_valid, 1'b0);

    // Backpressure: fill, drop one, then push and pop together while full.
    do_reset();
    pop_count = 0;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_instr(), $urandom, $urandom, 1'b0);
    check("full_no_overflow", bus.overflow, 1'b0);
    cycle(1'b1, rand_instr(), $urandom, $urandom, 1'b0);
    check("drop_overflow", bus.overflow, 1'b1);
    check("drop_cnt_one", bus.drop_cnt, 8'd1);
    cycle(1'b1, rand_instr(), $urandom, $urandom, 1'b1);
    check("full_pushpop_drop", bus.drop_cnt, 8'd1);
    check("full_pushpop_valid", bus.trc_valid, 1'b1);
    repeat (20) cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("drained_count", pop_count, 17);

    // Random traffic with frequent backpressure.
    do_reset();
    repeat (150) cycle($urandom_range(0, 99) < 60, rand_instr(), $urandom, $urandom,
                       $urandom_range(0, 99) < 40);
    repeat (20) cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Reset between edges with records buffered and sticky flags possibly set.
    repeat (5) cycle(1'b1, rand_instr(), $urandom, $urandom, 1'b0);
    check("pre_reset_valid", bus.trc_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_valid", bus.trc_valid, 1'b0);
    check("async_data", bus.trc_data, '0);
    check("async_overflow", bus.overflow, 1'b0);
    check("async_drop", bus.drop_cnt, 8'd0);
    check("async_halt", bus.halt, 1'b0);
    #1;
    rst = 1'b0;
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("post_reset_valid", bus.trc_valid, 1'b0);

    // Halt: retire every cycle past the budget, then keep draining.
    do_reset();
    repeat (230) cycle(1'b1, rand_instr(), $urandom, $urandom, ($urandom % 4) != 0);
    repeat (20) cycle(1'b1, rand_instr(), $urandom, $urandom, 1'b1);
    check("halt_set", bus.halt, 1'b1);
    check("halt_drained", bus.trc_valid, 1'b0);
    check("halt_last_cyc", last_pop_cyc, 16'(STOP - 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
